// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready start and result handshakes.
// Optional feature macro MULDIV_FAST_MUL_EN: single-cycle multiplies, divides stay iterative.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [TAGW-1:0] tag_in,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] result_tag
);
  localparam int unsigned CNTW = $clog2(XLEN) + 1;
  localparam int unsigned PW   = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_f3;
  logic [TAGW-1:0] r_tag;
  logic            r_neg_res, r_neg_rem;
  logic [XLEN-1:0] r_acc, r_lo, r_opb, r_result;
  logic [CNTW-1:0] r_cnt;

  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div_zero, w_ovf, w_fast, w_direct, w_accept, w_last;
  logic [XLEN-1:0] w_special_res, w_fast_res;

  // Operand decode at accept: signedness, magnitudes and RISC-V special cases
  assign w_is_div   = funct3[2];
  assign w_a_signed = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = funct3[2] ? !funct3[0] : !funct3[1];
  assign w_a_neg    = w_a_signed & srca[XLEN-1];
  assign w_b_neg    = w_b_signed & srcb[XLEN-1];
  assign w_abs_a    = w_a_neg ? -srca : srca;
  assign w_abs_b    = w_b_neg ? -srcb : srcb;
  assign w_div_zero = w_is_div & (srcb == '0);
  assign w_ovf      = w_is_div & !funct3[0] & (srca == MOST_NEG) & (srcb == '1);
  assign w_special_res = w_div_zero ? (funct3[1] ? srca : '1)
                                    : (funct3[1] ? '0 : MOST_NEG);

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] w_fa, w_fb, w_fprod;
  // Sign-extended operands give the exact product modulo 2^PW for all three signedness mixes
  assign w_fa       = {{XLEN{w_a_signed & srca[XLEN-1]}}, srca};
  assign w_fb       = {{XLEN{w_b_signed & srcb[XLEN-1]}}, srcb};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast     = !w_is_div;
  assign w_fast_res = (funct3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[PW-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_accept = start_valid & start_ready & !flush;
  assign w_direct = w_div_zero | w_ovf | w_fast;
  assign w_last   = (r_cnt == CNTW'(1));

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0]   w_sum, w_shift;
  logic [XLEN-1:0] w_add, w_diff, w_mul_acc, w_mul_lo, w_div_acc, w_div_lo;
  logic            w_ge;
  logic [PW-1:0]   w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo_s, w_rem_s, w_calc_res;

  assign w_add     = r_lo[0] ? r_opb : '0;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_add};
  assign w_mul_acc = w_sum[XLEN:1];
  assign w_mul_lo  = {w_sum[0], r_lo[XLEN-1:1]};
  assign w_shift   = {r_acc, r_lo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_opb});
  assign w_diff    = w_shift[XLEN-1:0] - r_opb;
  assign w_div_acc = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_div_lo  = {r_lo[XLEN-2:0], w_ge};

  assign w_prod   = {w_mul_acc, w_mul_lo};
  assign w_prod_s = r_neg_res ? -w_prod : w_prod;
  assign w_quo_s  = r_neg_res ? -w_div_lo : w_div_lo;
  assign w_rem_s  = r_neg_rem ? -w_div_acc : w_div_acc;

  always_comb begin
    w_calc_res = w_prod_s[PW-1:XLEN];
    case (r_f3)
      3'b000:         w_calc_res = w_prod_s[XLEN-1:0];
      3'b100, 3'b101: w_calc_res = w_quo_s;
      3'b110, 3'b111: w_calc_res = w_rem_s;
      default:        w_calc_res = w_prod_s[PW-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_direct ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (result_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f3      <= '0;
      r_tag     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_f3      <= funct3;
      r_tag     <= tag_in;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_acc     <= '0;
      r_lo      <= w_is_div ? w_abs_a : w_abs_b;
      r_opb     <= w_is_div ? w_abs_b : w_abs_a;
      r_cnt     <= CNTW'(XLEN);
      if (w_direct) r_result <= (w_div_zero | w_ovf) ? w_special_res : w_fast_res;
    end else if ((r_state == CALC) && !flush) begin
      r_acc <= r_f3[2] ? w_div_acc : w_mul_acc;
      r_lo  <= r_f3[2] ? w_div_lo  : w_mul_lo;
      r_cnt <= r_cnt - CNTW'(1);
      if (w_last) r_result <= w_calc_res;
    end
  end

  assign start_ready  = (r_state == IDLE) & !flush;
  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign result       = r_result;
  assign result_tag   = r_tag;
endmodule
